// File: rtl/cv32e40s_sleep_unit_mc_if.sv
// Controller-side signals of the multi-domain sleep unit.
// All signals are level-sensitive and sampled on clk_ungated_i; there is no
// valid/ready pairing. The controller (master) holds busy/wake/fetch-enable
// levels for as long as they apply, and the sleep unit (slave) reports its
// state every cycle.
interface cv32e40s_sleep_unit_mc_if #(
  parameter int NUM_BUSY = 3,
  parameter int NUM_AUX  = 1
);
  localparam int AUX_W = (NUM_AUX > 0) ? NUM_AUX : 1;

  logic                fetch_enable_i;
  logic [NUM_BUSY-1:0] busy_i;
  logic                wake_from_sleep_i;
  logic [AUX_W-1:0]    aux_busy_i;
  logic                core_sleep_o;
  logic                fetch_enable_o;
  logic [2:0]          sleep_state_o;

  modport master (
    output fetch_enable_i, busy_i, wake_from_sleep_i, aux_busy_i,
    input  core_sleep_o, fetch_enable_o, sleep_state_o
  );

  modport slave (
    input  fetch_enable_i, busy_i, wake_from_sleep_i, aux_busy_i,
    output core_sleep_o, fetch_enable_o, sleep_state_o
  );
endinterface

// File: rtl/cv32e40s_sleep_unit_mc.sv
// Multi-domain sleep unit: gates the core clock and NUM_AUX auxiliary clocks
// from the free-running clock, with idle hysteresis before sleep, a wake-up
// settle delay, and per-domain auxiliary idle gating.

// Behavioural clock gate; LIB selects the cell style.
module cv32e40s_clock_gate #(
  parameter int LIB = 0
) (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);
  logic en_q;

  if (LIB == 0) begin : gen_latch_icg
    // Latch is transparent while the clock is low, so the enable is stable during the high phase.
    always_latch begin
      if (!clk_i) en_q <= en_i | scan_cg_en_i;
    end
  end else begin : gen_flop_icg
    // Negative-edge flop variant for libraries without a latch-based cell.
    always_ff @(negedge clk_i) begin
      en_q <= en_i | scan_cg_en_i;
    end
  end

  assign clk_o = clk_i & en_q;
endmodule

module cv32e40s_sleep_unit_mc #(
  parameter int LIB            = 0,
  parameter int NUM_BUSY       = 3,
  parameter int NUM_AUX        = 1,
  parameter int IDLE_DELAY     = 0,
  parameter int WAKE_DELAY     = 0,
  parameter int AUX_IDLE_DELAY = 2
) (
  input  logic                                  clk_ungated_i,
  input  logic                                  rst_n,
  input  logic                                  scan_cg_en_i,
  cv32e40s_sleep_unit_mc_if.slave               ctrl_if,
  output logic                                  clk_gated_o,
  output logic [((NUM_AUX > 0) ? NUM_AUX : 1)-1:0] clk_aux_gated_o
);
  localparam int MAX_DLY   = (IDLE_DELAY > WAKE_DELAY) ? IDLE_DELAY : WAKE_DELAY;
  localparam int CNT_W     = $clog2(((MAX_DLY > 0) ? MAX_DLY : 1) + 1);
  localparam int AUX_CNT_W = $clog2(((AUX_IDLE_DELAY > 0) ? AUX_IDLE_DELAY : 1) + 1);
  localparam logic [CNT_W-1:0]     IDLE_LOAD = CNT_W'((IDLE_DELAY > 0) ? IDLE_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0]     WAKE_LOAD = CNT_W'((WAKE_DELAY > 0) ? WAKE_DELAY - 1 : 0);
  localparam logic [AUX_CNT_W-1:0] AUX_LOAD  = AUX_CNT_W'(AUX_IDLE_DELAY);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_RUN   = 3'd1,
    S_IDLE  = 3'd2,
    S_SLEEP = 3'd3,
    S_WAKE  = 3'd4
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                fetch_enable_q;
  logic                busy_q;
  logic                core_en;
  logic                wake;
  logic [NUM_BUSY-1:0] busy_vec;

  assign busy_vec = ctrl_if.busy_i;
  assign wake     = ctrl_if.wake_from_sleep_i;

  // Sticky fetch enable and registered core activity.
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      fetch_enable_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      if (ctrl_if.fetch_enable_i) fetch_enable_q <= 1'b1;
      busy_q <= |busy_vec;
    end
  end

  // Core clock enable from the registered state plus the live wake request.
  // With no idle hysteresis RUN gates as soon as the core is idle, which keeps
  // the enable identical to the single-gate unit it replaces.
  always_comb begin
    core_en = 1'b0;
    unique case (state_q)
      S_RUN:   core_en = (IDLE_DELAY == 0) ? (busy_q || wake) : 1'b1;
      S_IDLE:  core_en = 1'b1;
      S_SLEEP: core_en = (WAKE_DELAY == 0) ? wake : 1'b0;
      default: core_en = 1'b0;
    endcase
  end

  // Sleep FSM with a shared idle/wake delay counter.
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (fetch_enable_q) state_q <= S_RUN;
        end
        S_RUN: begin
          if (!busy_q && !wake) begin
            if (IDLE_DELAY == 0) begin
              state_q <= S_SLEEP;
            end else begin
              state_q <= S_IDLE;
              cnt_q   <= IDLE_LOAD;
            end
          end
        end
        S_IDLE: begin
          // Renewed activity takes priority over an expiring idle count.
          if (busy_q || wake)   state_q <= S_RUN;
          else if (cnt_q == '0) state_q <= S_SLEEP;
          else                  cnt_q   <= cnt_q - 1'b1;
        end
        S_SLEEP: begin
          if (wake) begin
            if (WAKE_DELAY == 0) begin
              state_q <= S_RUN;
            end else begin
              state_q <= S_WAKE;
              cnt_q   <= WAKE_LOAD;
            end
          end
        end
        S_WAKE: begin
          // Once started, a wake always completes even if the request drops.
          if (cnt_q == '0) state_q <= S_RUN;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= S_OFF;
      endcase
    end
  end

  assign ctrl_if.core_sleep_o   = (state_q == S_SLEEP) && !core_en;
  assign ctrl_if.fetch_enable_o = fetch_enable_q;
  assign ctrl_if.sleep_state_o  = state_q;

  cv32e40s_clock_gate #(.LIB(LIB)) core_clock_gate_i (
    .clk_i        (clk_ungated_i),
    .en_i         (core_en),
    .scan_cg_en_i (scan_cg_en_i),
    .clk_o        (clk_gated_o)
  );

  if (NUM_AUX > 0) begin : gen_aux
    for (genvar d = 0; d < NUM_AUX; d++) begin : gen_dom
      logic                 aux_busy_q;
      logic [AUX_CNT_W-1:0] aux_cnt_q;
      logic                 aux_en;

      // Per-domain busy register and idle countdown, saturating at zero.
      always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
          aux_busy_q <= 1'b0;
          aux_cnt_q  <= '0;
        end else begin
          aux_busy_q <= ctrl_if.aux_busy_i[d];
          if (aux_busy_q)           aux_cnt_q <= AUX_LOAD;
          else if (aux_cnt_q != '0) aux_cnt_q <= aux_cnt_q - 1'b1;
        end
      end

      // An aux domain only runs while the core clock runs.
      assign aux_en = core_en && (aux_busy_q || (aux_cnt_q != '0));

      cv32e40s_clock_gate #(.LIB(LIB)) aux_clock_gate_i (
        .clk_i        (clk_ungated_i),
        .en_i         (aux_en),
        .scan_cg_en_i (scan_cg_en_i),
        .clk_o        (clk_aux_gated_o[d])
      );
    end
  end else begin : gen_no_aux
    assign clk_aux_gated_o = 1'b0;
  end
endmodule

// File: tb/tb_cv32e40s_sleep_unit_mc.sv
// Bench for the multi-domain sleep unit: a hysteresis/aux configuration under
// directed steps, and the default configuration against the single-gate
// enable equation under random busy/wake traffic.
module tb_cv32e40s_sleep_unit_mc;
  localparam int W = 3;
  localparam logic [2:0] ST_OFF = 3'd0, ST_RUN = 3'd1, ST_IDLE = 3'd2,
                         ST_SLEEP = 3'd3, ST_WAKE = 3'd4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scan  = 1'b0;

  // Clock and reset
  always #5 clk = ~clk;

  cv32e40s_sleep_unit_mc_if #(.NUM_BUSY(3), .NUM_AUX(1)) ifa ();
  cv32e40s_sleep_unit_mc_if #(.NUM_BUSY(3), .NUM_AUX(2)) ifb ();

  logic       clk_a;
  logic [0:0] aux_a;
  logic       clk_b;
  logic [1:0] aux_b;

  cv32e40s_sleep_unit_mc dut_a (
    .clk_ungated_i   (clk),
    .rst_n           (rst_n),
    .scan_cg_en_i    (scan),
    .ctrl_if         (ifa),
    .clk_gated_o     (clk_a),
    .clk_aux_gated_o (aux_a)
  );

  cv32e40s_sleep_unit_mc #(
    .NUM_BUSY(3), .NUM_AUX(2), .IDLE_DELAY(4), .WAKE_DELAY(3), .AUX_IDLE_DELAY(2)
  ) dut_b (
    .clk_ungated_i   (clk),
    .rst_n           (rst_n),
    .scan_cg_en_i    (scan),
    .ctrl_if         (ifb),
    .clk_gated_o     (clk_b),
    .clk_aux_gated_o (aux_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  logic [W-1:0] exp_q[$];
  logic [0:0]   leg_q[$];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  // Driver for the hysteresis unit: drive one cycle, check the combinational
  // view of that cycle, then check the gated edges that close it.
  task automatic cyc_b(input logic [2:0] busy, input logic wake, input logic [1:0] aux,
                       input logic fe, input logic sc, input logic [2:0] e_state,
                       input logic e_sleep, input logic e_fe, input logic [2:0] e_en);
    logic [W-1:0] exp_en;
    ifb.busy_i            = busy;
    ifb.wake_from_sleep_i = wake;
    ifb.aux_busy_i        = aux;
    ifb.fetch_enable_i    = fe;
    scan                  = sc;
    exp_q.push_back(e_en);
    #3;
    chk("state", 8'(ifb.sleep_state_o), 8'(e_state));
    chk("core_sleep", 8'(ifb.core_sleep_o), 8'(e_sleep));
    chk("fetch_en", 8'(ifb.fetch_enable_o), 8'(e_fe));
    @(posedge clk);
    #1;
    exp_en = exp_q.pop_front();
    chk("gated_clks", 8'({aux_b, clk_b}), 8'(exp_en));
    cyc_n++;
  endtask

  logic       fe_q_m   = 1'b0;
  logic       busy_q_m = 1'b0;
  logic       en_m;
  logic       fe_a;
  logic       w_a;
  logic [2:0] b_a;

  initial begin
    ifa.fetch_enable_i = 1'b0; ifa.busy_i = '0; ifa.wake_from_sleep_i = 1'b0; ifa.aux_busy_i = '0;
    ifb.fetch_enable_i = 1'b0; ifb.busy_i = '0; ifb.wake_from_sleep_i = 1'b0; ifb.aux_busy_i = '0;
    @(posedge clk);
    #1;

    // In reset: fetch enable ignored, everything gated
    cyc_b(3'b000, 0, 2'b00, 1, 0, ST_OFF, 0, 0, 3'b000);
    cyc_b(3'b000, 0, 2'b00, 1, 0, ST_OFF, 0, 0, 3'b000);
    rst_n = 1'b1;
    cyc_n = 0;
    for (int i = 0; i < 5; i++) cyc_b(3'b000, 0, 2'b00, 0, 0, ST_OFF, 0, 0, 3'b000);
    // Fetch enable pulse at cycle 5, sticky at 6, RUN at 7
    cyc_b(3'b000, 0, 2'b00, 1, 0, ST_OFF,  0, 0, 3'b000);
    cyc_b(3'b001, 0, 2'b00, 0, 0, ST_OFF,  0, 1, 3'b000);
    cyc_b(3'b001, 0, 2'b00, 0, 0, ST_RUN,  0, 1, 3'b001);
    // Aux domain 1 pulse: three enabled cycles, domain 0 untouched
    cyc_b(3'b001, 0, 2'b10, 0, 0, ST_RUN,  0, 1, 3'b001);
    cyc_b(3'b001, 0, 2'b00, 0, 0, ST_RUN,  0, 1, 3'b101);
    cyc_b(3'b001, 0, 2'b00, 0, 0, ST_RUN,  0, 1, 3'b101);
    cyc_b(3'b001, 0, 2'b00, 0, 0, ST_RUN,  0, 1, 3'b101);
    cyc_b(3'b001, 0, 2'b00, 0, 0, ST_RUN,  0, 1, 3'b001);
    // Idle, then busy again during IDLE: back to RUN without sleeping
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_RUN,  0, 1, 3'b001);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_RUN,  0, 1, 3'b001);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_IDLE, 0, 1, 3'b001);
    cyc_b(3'b100, 0, 2'b00, 0, 0, ST_IDLE, 0, 1, 3'b001);
    cyc_b(3'b100, 0, 2'b00, 0, 0, ST_IDLE, 0, 1, 3'b001);
    cyc_b(3'b100, 0, 2'b00, 0, 0, ST_RUN,  0, 1, 3'b001);
    // Full idle: one RUN cycle, four IDLE cycles, then SLEEP
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_RUN,  0, 1, 3'b001);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_RUN,  0, 1, 3'b001);
    for (int i = 0; i < 4; i++) cyc_b(3'b000, 0, 2'b00, 0, 0, ST_IDLE, 0, 1, 3'b001);
    // Asleep: aux busy and core busy alone keep everything gated
    cyc_b(3'b000, 0, 2'b11, 0, 0, ST_SLEEP, 1, 1, 3'b000);
    cyc_b(3'b010, 0, 2'b11, 0, 0, ST_SLEEP, 1, 1, 3'b000);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_SLEEP, 1, 1, 3'b000);
    // Scan forces all gates open without disturbing the FSM
    cyc_b(3'b000, 0, 2'b00, 0, 1, ST_SLEEP, 1, 1, 3'b111);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_SLEEP, 1, 1, 3'b000);
    // One-cycle wake pulse: three WAKE cycles, clock back on the fourth
    cyc_b(3'b000, 1, 2'b00, 0, 0, ST_SLEEP, 1, 1, 3'b000);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_WAKE,  0, 1, 3'b000);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_WAKE,  0, 1, 3'b000);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_WAKE,  0, 1, 3'b000);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_RUN,   0, 1, 3'b001);
    for (int i = 0; i < 4; i++) cyc_b(3'b000, 0, 2'b00, 0, 0, ST_IDLE, 0, 1, 3'b001);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_SLEEP, 1, 1, 3'b000);
    cyc_b(3'b000, 1, 2'b00, 0, 0, ST_SLEEP, 1, 1, 3'b000);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_WAKE,  0, 1, 3'b000);
    // Reset in WAKE: back to OFF with reset outputs; scan still opens gates
    rst_n = 1'b0;
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_OFF, 0, 0, 3'b000);
    cyc_b(3'b000, 0, 2'b00, 0, 1, ST_OFF, 0, 0, 3'b111);
    rst_n = 1'b1;
    cyc_b(3'b000, 0, 2'b00, 0, 1, ST_OFF, 0, 0, 3'b111);
    cyc_b(3'b000, 0, 2'b00, 0, 1, ST_OFF, 0, 0, 3'b111);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_OFF, 0, 0, 3'b000);
    cyc_b(3'b000, 0, 2'b00, 0, 0, ST_OFF, 0, 0, 3'b000);

    // Default unit against the single-gate equation fe_q && (wake || busy_q).
    // Busy sources only rise while the core clock runs, as real core logic would.
    for (int i = 0; i < 10000; i++) begin
      fe_a = (i == 0);
      w_a  = (i < 3) ? 1'b0 : ($urandom_range(0, 3) == 0);
      en_m = fe_q_m && (w_a || busy_q_m);
      b_a  = (i >= 3 && en_m && $urandom_range(0, 2) != 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      ifa.fetch_enable_i    = fe_a;
      ifa.wake_from_sleep_i = w_a;
      ifa.busy_i            = b_a;
      leg_q.push_back(en_m);
      @(posedge clk);
      #1;
      chk("legacy_en", 8'(clk_a), 8'(leg_q.pop_front()));
      fe_q_m   = fe_q_m | fe_a;
      busy_q_m = |b_a;
      cyc_n++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
